serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one 1-bit adder cell over two WIDTH-bit operands, one bit per clock, LSB first.
- The cell is built from two half adders plus an OR (s = a^b^c, c' = ab | c(a^b)).
- Provides a start/busy/done handshake so upstream logic can issue multi-bit additions without a WIDTH-bit ripple adder.
- Sits between a register-level requester and the shared bit-level adder datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; operands sampled on the clk edge where start=1 is accepted.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result, held until the next completion.
- cout  output  1  registered carry out of the MSB, held with sum.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a and b into operand shift registers, clears carry and counter, then -> RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1 every cycle.
  - Each cycle the bit cell consumes bit0 of both shift registers plus the carry.
  - The sum bit shifts into the MSB of the result shift register; the operand registers shift right; the carry updates; the counter increments.
  - When the counter reaches WIDTH-1 (the last bit is processed this cycle):
    - load sum from the completed result shift register and cout from the final carry;
    - -> DONE.
  - start is ignored in RUN; a, b and the outputs are unaffected.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - start=1 here is accepted exactly as in IDLE (-> RUN, new operands latched); otherwise -> IDLE.
- Latency:
  - Start accepted at edge k gives busy=1 from edge k through edge k+WIDTH.
  - done=1 and valid sum/cout follow edge k+WIDTH, i.e. WIDTH+1 cycles after the request.
- Throughput: one addition per WIDTH+1 cycles with back-to-back starts.
- Arithmetic: unsigned modulo 2^WIDTH, with cout = bit WIDTH of a+b.
- sum/cout change only on the completion edge or on reset; they never show partial results.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs return to 0.
- Operand changes after acceptance have no effect on the running addition.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), loaded on the completion edge with the signed two's-complement overflow;
  - ovf = carry into MSB XOR carry out of MSB;
  - held with sum.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- Reset then 0x00+0x00 -> done pulses 9 cycles after start, sum=0x00, cout=0, busy high exactly 8 cycles.
- 0xFF+0x01 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
- 0x5A+0x3C -> sum=0x96, cout=0. Then 0x7F+0x01 -> sum=0x80, cout=0, ovf=1 (macro on).
- Check start ignored while busy:
  - start 0x10+0x20, then pulse start with 0xAA+0xAA at cycle 3 of RUN;
  - expect result sum=0x30, cout=0, and a single done pulse.
- Check reset mid-operation:
  - assert rst_n=0 asynchronously at RUN cycle 4 of 0xF0+0x0F;
  - busy/sum/cout go to 0 immediately and no done pulse occurs;
  - after release, 0x01+0x02 gives sum=0x03.
- Check back-to-back starts:
  - hold start=1 continuously with 0x80+0x80, then 0x0F+0x01;
  - expect done pulses 9 cycles apart;
  - first result sum=0x00, cout=1; second result sum=0x10, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer.
// A single full-adder cell (two half adders plus an OR) is reused once per
// clock, LSB first, to add two WIDTH-bit operands.
// The start/busy/done handshake lets a register-level requester issue
// additions to the shared cell.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output, which is the
// signed two's-complement overflow flag.
module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  // Bit cell: the first half adder takes a and b; the second adds the carry in.
  logic w_ha1_s;
  logic w_ha1_c;
  logic w_ha2_s;
  logic w_ha2_c;
  logic w_s;
  logic w_c;

  assign w_ha1_s = r_a[0] ^ r_b[0];
  assign w_ha1_c = r_a[0] & r_b[0];
  assign w_ha2_s = w_ha1_s ^ r_carry;
  assign w_ha2_c = w_ha1_s & r_carry;
  assign w_s     = w_ha2_s;
  assign w_c     = w_ha1_c | w_ha2_c;

  // The result register with this cycle's sum bit shifted in at the MSB.
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_accept;

  assign w_res_next = {w_s, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // A new request is taken in IDLE, and also in DONE so that back-to-back
  // additions lose no extra cycle.
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand and result shifting; visible outputs load only on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        sum  <= w_res_next;
        cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
        // r_carry holds the carry into the MSB; w_c is the carry out of it.
        ovf  <= r_carry ^ w_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl.
// The expected results come from plain integer arithmetic on the operands.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one addition, optionally pulsing a spurious start during RUN
  // (at loop index glitch_at; use -1 for none). Check the latency, the busy
  // length, that the outputs hold during RUN, the result, and a single done.
  task automatic run_add(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input int glitch_at);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    int               n;
    int               nbusy;
    exp       = {1'b0, op_a} + {1'b0, op_b};
    held_sum  = sum;
    held_cout = cout;
    a = op_a; b = op_b; start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    n = 0; nbusy = 0;
    while (!done && n < 4 * WIDTH) begin
      if (busy) nbusy++;
      check_eq("hold_sum", 32'(sum), 32'(held_sum));
      check_eq("hold_cout", 32'(cout), 32'(held_cout));
      if (n == glitch_at) begin
        start = 1'b1; a = 8'hAA; b = 8'hAA;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("latency", 32'(n), 32'(WIDTH));
    check_eq("busy_len", 32'(nbusy), 32'(WIDTH));
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    check_eq("cout", 32'(cout), 32'(exp[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("ovf", 32'(ovf),
             32'((op_a[WIDTH-1] == op_b[WIDTH-1]) && (exp[WIDTH-1] != op_a[WIDTH-1])));
`endif
    $display("[TB] add 0x%0h + 0x%0h -> sum 0x%0h cout %0d (latency %0d)",
             op_a, op_b, sum, cout, n + 1);
    step();
    check_eq("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int ndone;
    int first_at;
    int second_at;
    logic saw_done;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    step();
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    run_add(8'h00, 8'h00, -1);
    run_add(8'hFF, 8'h01, -1);
    run_add(8'h5A, 8'h3C, -1);
    run_add(8'h7F, 8'h01, -1);
    // A start pulse during RUN cycle 3 must be ignored.
    run_add(8'h10, 8'h20, 2);
    repeat (3) step();
    check_eq("no_extra_done", 32'(done), 32'd0);

    // Asynchronous reset in the middle of an addition.
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_sum", 32'(sum), 32'd0);
    check_eq("mid_rst_cout", 32'(cout), 32'd0);
    saw_done = 1'b0;
    repeat (2 * WIDTH) begin
      step();
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2 * WIDTH) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check_eq("mid_rst_no_done", 32'(saw_done), 32'd0);
    $display("[TB] reset mid-run: busy %0d sum 0x%0h", busy, sum);
    run_add(8'h01, 8'h02, -1);

    // Start held high: two additions back to back.
    a = 8'h80; b = 8'h80; start = 1'b1;
    step();
    a = 8'h0F; b = 8'h01;
    n = 0; ndone = 0; first_at = -1; second_at = -1;
    while (ndone < 2 && n < 4 * WIDTH + 8) begin
      step();
      n++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_at = n;
          check_eq("b2b_sum1", 32'(sum), 32'h00);
          check_eq("b2b_cout1", 32'(cout), 32'd1);
          $display("[TB] b2b #1 sum 0x%0h cout %0d at cycle %0d", sum, cout, n);
        end else begin
          second_at = n;
          start = 1'b0;
          check_eq("b2b_sum2", 32'(sum), 32'h10);
          check_eq("b2b_cout2", 32'(cout), 32'd0);
          $display("[TB] b2b #2 sum 0x%0h cout %0d at cycle %0d", sum, cout, n);
        end
      end
    end
    start = 1'b0;
    check_eq("b2b_count", 32'(ndone), 32'd2);
    check_eq("b2b_first", 32'(first_at), 32'(WIDTH));
    check_eq("b2b_gap", 32'(second_at - first_at), 32'(WIDTH + 1));
    step();
    check_eq("b2b_idle", 32'(done), 32'd0);

    // Random operands checked against integer addition.
    repeat (20) begin
      run_add(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
